// File: rtl/icache_refill_arbiter_pkg.sv
// Shared types and constants for the I/D line-refill arbiter.
package refill_arb_pkg;

   localparam int unsigned LINE_OFFSET_BITS = 4;
   localparam int unsigned DEF_ADDR_W       = 32;
   localparam int unsigned DEF_LINE_W       = 128;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      FILL
   } arb_state_t;

   typedef enum logic {
      OWN_I,
      OWN_D
   } owner_t;

endpackage

// File: rtl/icache_refill_arbiter_timeout_ctr.sv
// Counts WAIT cycles without a memory answer; expired fires on the cycle whose
// increment would reach TIMEOUT, so the abort lands on that same edge.
module refill_timeout_ctr #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   assign expired = count_en && (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clear || expired) begin
         cnt <= '0;
      end else if (count_en) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/icache_refill_arbiter.sv
// Shares one line-wide memory read port between I- and D-cache refills.
// Define ICACHE_REFILL_RR_EN for round-robin tie-breaking (default: D over I).
module icache_refill_arbiter
   import refill_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned LINE_W  = DEF_LINE_W,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_miss,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              d_miss,
   input  logic [ADDR_W-1:0] d_addr,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic [LINE_W-1:0] mem_rdata,
   output logic [LINE_W-1:0] fill_data,
   output logic [ADDR_W-1:0] fill_addr,
   output logic              i_fill,
   output logic              d_fill,
   output logic              stall_fetch,
   output logic              stall_mem,
   output logic              busy,
   output logic              err
);

   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(2 ** LINE_OFFSET_BITS - 1);

   arb_state_t        state, nxt_state;
   owner_t            owner, nxt_owner, grant;
   logic              nxt_req, nxt_ifill, nxt_dfill, nxt_err;
   logic [ADDR_W-1:0] nxt_addr, nxt_faddr, grant_addr;
   logic [LINE_W-1:0] nxt_fdata;
   logic              expired;

`ifdef ICACHE_REFILL_RR_EN
   owner_t            last_grant, nxt_last_grant;

   always_comb begin
      if (i_miss && d_miss) begin
         grant = (last_grant == OWN_D) ? OWN_I : OWN_D;
      end else begin
         grant = d_miss ? OWN_D : OWN_I;
      end
   end
`else
   always_comb begin
      grant = d_miss ? OWN_D : OWN_I;
   end
`endif

   assign grant_addr = (grant == OWN_D) ? d_addr : i_addr;

   refill_timeout_ctr #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (state != WAIT),
      .count_en((state == WAIT) && !mem_ready),
      .expired (expired)
   );

   always_comb begin
      nxt_state = state;
      nxt_owner = owner;
      nxt_req   = mem_req;
      nxt_addr  = mem_addr;
      nxt_fdata = fill_data;
      nxt_faddr = fill_addr;
      nxt_ifill = 1'b0;
      nxt_dfill = 1'b0;
      nxt_err   = err;
`ifdef ICACHE_REFILL_RR_EN
      nxt_last_grant = last_grant;
`endif
      case (state)
         IDLE: begin
            if (i_miss || d_miss) begin
               nxt_owner = grant;
               nxt_addr  = grant_addr & LINE_MASK;
               nxt_req   = 1'b1;
               nxt_state = WAIT;
`ifdef ICACHE_REFILL_RR_EN
               nxt_last_grant = grant;
`endif
            end
         end
         WAIT: begin
            // A late answer on the final timeout cycle still wins over the abort.
            if (mem_ready) begin
               nxt_fdata = mem_rdata;
               nxt_faddr = mem_addr;
               nxt_req   = 1'b0;
               nxt_ifill = (owner == OWN_I);
               nxt_dfill = (owner == OWN_D);
               nxt_state = FILL;
            end else if (expired) begin
               nxt_req   = 1'b0;
               nxt_err   = 1'b1;
               nxt_state = IDLE;
            end
         end
         FILL: begin
            nxt_state = IDLE;
         end
         default: begin
            nxt_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         owner     <= OWN_D;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         fill_data <= '0;
         fill_addr <= '0;
         i_fill    <= 1'b0;
         d_fill    <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= nxt_state;
         owner     <= nxt_owner;
         mem_req   <= nxt_req;
         mem_addr  <= nxt_addr;
         fill_data <= nxt_fdata;
         fill_addr <= nxt_faddr;
         i_fill    <= nxt_ifill;
         d_fill    <= nxt_dfill;
         err       <= nxt_err;
      end
   end

`ifdef ICACHE_REFILL_RR_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant <= OWN_D;
      end else begin
         last_grant <= nxt_last_grant;
      end
   end
`endif

   assign busy        = (state != IDLE);
   assign stall_fetch = i_miss | (busy & (owner == OWN_I));
   assign stall_mem   = d_miss | (busy & (owner == OWN_D));

endmodule

// File: tb/tb_icache_refill_arbiter.sv
// Directed bench for icache_refill_arbiter with a transaction-level reference model.
module tb_icache_refill_arbiter;

   localparam int AW = 32;
   localparam int LW = 128;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_miss = 1'b0, d_miss = 1'b0;
   logic [AW-1:0] i_addr = '0, d_addr = '0;
   logic          mem_ready = 1'b0;
   logic [LW-1:0] mem_rdata = '0;
   logic          mem_req, i_fill, d_fill, stall_fetch, stall_mem, busy, err;
   logic [AW-1:0] mem_addr, fill_addr;
   logic [LW-1:0] fill_data;

   always #5 clk = ~clk;

   icache_refill_arbiter #(
      .ADDR_W (AW),
      .LINE_W (LW),
      .TIMEOUT(TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_miss     (i_miss),
      .i_addr     (i_addr),
      .d_miss     (d_miss),
      .d_addr     (d_addr),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata),
      .fill_data  (fill_data),
      .fill_addr  (fill_addr),
      .i_fill     (i_fill),
      .d_fill     (d_fill),
      .stall_fetch(stall_fetch),
      .stall_mem  (stall_mem),
      .busy       (busy),
      .err        (err)
   );

   // Reference model: one outstanding transaction (phase 0 none, 1 outstanding, 2 filling).
   logic          m_req, m_ifill, m_dfill, m_err;
   logic [AW-1:0] m_addr, m_faddr;
   logic [LW-1:0] m_fdata;
   bit            m_own_i, m_last_i, pick_i;
   int            m_phase, m_waited;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_req = 0; m_addr = 0; m_faddr = 0; m_fdata = 0;
         m_ifill = 0; m_dfill = 0; m_err = 0;
         m_own_i = 0; m_last_i = 0; m_phase = 0; m_waited = 0;
      end else begin
         m_ifill = 0;
         m_dfill = 0;
         if (m_phase == 2) begin
            m_phase = 0;
         end else if (m_phase == 1) begin
            if (mem_ready) begin
               m_fdata = mem_rdata;
               m_faddr = m_addr;
               m_req   = 0;
               if (m_own_i) m_ifill = 1; else m_dfill = 1;
               m_phase = 2;
            end else begin
               m_waited++;
               if (m_waited == TO) begin
                  m_req = 0;
                  m_err = 1;
                  m_phase = 0;
               end
            end
         end else if (i_miss || d_miss) begin
`ifdef ICACHE_REFILL_RR_EN
            pick_i = (i_miss && d_miss) ? !m_last_i : i_miss;
            m_last_i = pick_i;
`else
            pick_i = !d_miss;
`endif
            m_own_i  = pick_i;
            m_addr   = (pick_i ? i_addr : d_addr) & 32'hFFFF_FFF0;
            m_req    = 1;
            m_phase  = 1;
            m_waited = 0;
         end
      end
   end

   int n_cmp = 0, n_bad = 0;
   int n_ifill = 0, n_dfill = 0;
   int mem_lat = -1, mem_cnt = 0;
   bit auto_drop = 1;
   logic [32:0]   fill_log[$];
   logic [LW-1:0] last_fdata;
   int            req_cycles;
   int            base;
   logic [32:0]   exp_first, exp_second;

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      logic e_busy;
      e_busy = (m_phase != 0);
      check("mem_req", mem_req, m_req);
      check("mem_addr", mem_addr, m_addr);
      check("fill_data", fill_data, m_fdata);
      check("fill_addr", fill_addr, m_faddr);
      check("i_fill", i_fill, m_ifill);
      check("d_fill", d_fill, m_dfill);
      check("err", err, m_err);
      check("busy", busy, e_busy);
      check("stall_fetch", stall_fetch, i_miss | (e_busy & m_own_i));
      check("stall_mem", stall_mem, d_miss | (e_busy & !m_own_i));
   endtask

   // One clock: cache/memory reactions just after the edge, model compare on the falling edge.
   task automatic run_cycle();
      @(posedge clk);
      #2;
      if (i_fill) begin
         n_ifill++;
         fill_log.push_back({1'b1, fill_addr});
         last_fdata = fill_data;
         if (auto_drop) i_miss = 0;
      end
      if (d_fill) begin
         n_dfill++;
         fill_log.push_back({1'b0, fill_addr});
         last_fdata = fill_data;
         if (auto_drop) d_miss = 0;
      end
      mem_ready = 0;
      if (!mem_req) begin
         mem_cnt = 0;
      end else if (mem_lat >= 0) begin
         if (mem_cnt == mem_lat) begin
            mem_ready = 1;
            mem_cnt = 0;
         end else begin
            mem_cnt++;
         end
      end
      @(negedge clk);
      compare_all();
   endtask

   task automatic wait_fills(input int target, input int budget, input string name);
      for (int k = 0; k < budget && (n_ifill + n_dfill) < target; k++) run_cycle();
      check(name, ((n_ifill + n_dfill) >= target), 1'b1);
   endtask

   initial begin
      #1;
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_fill_data", fill_data, '0);
      run_cycle();
      run_cycle();
      rst = 1;
      run_cycle();
      run_cycle();

      // simultaneous misses
      i_addr = 32'h40; d_addr = 32'h80; i_miss = 1; d_miss = 1;
      mem_lat = 0; mem_rdata = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
      wait_fills(2, 20, "tie_fill_timeout");
`ifdef ICACHE_REFILL_RR_EN
      exp_first = {1'b1, 32'h40}; exp_second = {1'b0, 32'h80};
`else
      exp_first = {1'b0, 32'h80}; exp_second = {1'b1, 32'h40};
`endif
      check("tie_first", fill_log[0], exp_first);
      check("tie_second", fill_log[1], exp_second);
      run_cycle();
      run_cycle();

      // I-miss only, memory answers 3 cycles after request
      base = n_ifill;
      i_addr = 32'h0000_0104; i_miss = 1; mem_lat = 3;
      mem_rdata = 128'hFFFFFFFF_00000000_FFFFFFFF_00007C00;
      run_cycle();
      check("t1_mem_req", mem_req, 1'b1);
      check("t1_mem_addr", mem_addr, 32'h100);
      check("t1_stall_fetch", stall_fetch, 1'b1);
      wait_fills(n_ifill + n_dfill + 1, 20, "t1_fill_timeout");
      check("t1_fill_data", last_fdata, 128'hFFFFFFFF_00000000_FFFFFFFF_00007C00);
      check("t1_fill_addr", fill_log[$], {1'b1, 32'h100});
      check("t1_dfill_count", n_dfill, 1);
      run_cycle();
      check("t1_ifill_count", n_ifill - base, 1);
      check("t1_ifill_pulse", i_fill, 1'b0);

      // memory never answers: timeout, then retry succeeds
      base = n_ifill + n_dfill;
      d_addr = 32'h308; d_miss = 1; mem_lat = -1;
      run_cycle();
      req_cycles = 0;
      for (int k = 0; k < 20 && mem_req; k++) begin
         req_cycles++;
         run_cycle();
      end
      check("t3_req_cycles", req_cycles, TO);
      check("t3_err", err, 1'b1);
      check("t3_no_fill", n_ifill + n_dfill, base);
      mem_lat = 0;
      wait_fills(base + 1, 20, "t3_retry_timeout");
      check("t3_retry_addr", fill_log[$], {1'b0, 32'h300});
      check("t3_err_sticky", err, 1'b1);
      run_cycle();

      // asynchronous reset in the middle of WAIT
      i_addr = 32'h500; i_miss = 1; mem_lat = -1;
      run_cycle();
      run_cycle();
      check("t4_busy_pre", busy, 1'b1);
      #1 rst = 0;
      #1;
      check("t4_mem_req", mem_req, 1'b0);
      check("t4_busy", busy, 1'b0);
      check("t4_err", err, 1'b0);
      i_miss = 0;
      run_cycle();
      rst = 1;
      run_cycle();
      run_cycle();
      check("t4_idle_after", busy, 1'b0);

      // miss withdrawn during WAIT still fills
      base = n_ifill;
      i_addr = 32'h208; i_miss = 1; mem_lat = 2;
      run_cycle();
      run_cycle();
      i_miss = 0;
      wait_fills(n_ifill + n_dfill + 1, 20, "t5_fill_timeout");
      check("t5_ifill_count", n_ifill - base, 1);
      check("t5_stall_in_fill", stall_fetch, 1'b1);
      run_cycle();
      check("t5_stall_after", stall_fetch, 1'b0);

      // mem_ready while idle is ignored
      base = n_ifill + n_dfill;
      mem_lat = -1; mem_ready = 1; mem_rdata = 128'hDEAD;
      run_cycle();
      run_cycle();
      check("t6_no_fill", n_ifill + n_dfill, base);
      check("t6_fill_addr", fill_addr, 32'h200);
      check("t6_busy", busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/icache_refill_arbiter.md
Name: icache_refill_arbiter

Overview:
- Miss/refill controller that shares the single 128-bit line-wide memory read port between the instruction-fetch cache and the data cache.
- On a miss it grants one requester and issues a line-aligned memory read with a req/ready handshake.
- It captures the 128-bit line, pulses a fill strobe to the owning cache and stalls the matching pipeline stage until the fill completes.
- A timeout counter flags a memory that never answers.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 128, cache line / memory data width (4 words)
TIMEOUT, 255, max cycles in WAIT before abort; counter width = clog2(TIMEOUT+1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
i_miss  input  1  instruction cache miss (level, held until line filled)
i_addr  input  ADDR_W  byte address of missing instruction
d_miss  input  1  data cache miss (level)
d_addr  input  ADDR_W  byte address of missing data
mem_req  output  1  memory read request (registered)
mem_addr  output  ADDR_W  line-aligned read address, bits [3:0]=0 (registered)
mem_ready  input  1  memory data valid this cycle
mem_rdata  input  LINE_W  memory line data
fill_data  output  LINE_W  captured line, valid with fill strobe
fill_addr  output  ADDR_W  line address of fill_data
i_fill  output  1  one-cycle write strobe to instruction cache
d_fill  output  1  one-cycle write strobe to data cache
stall_fetch  output  1  freeze PC / IF stage
stall_mem  output  1  freeze MEM stage and upstream
busy  output  1  state != IDLE
err  output  1  sticky timeout flag

Behaviour:
- Reset (rst=0, async): state=IDLE; mem_req=0, mem_addr=0, fill_data=0, fill_addr=0, i_fill=0, d_fill=0, err=0, owner=D, last_grant=D, timeout count=0. Outputs drop immediately, not at the next edge.
- FSM IDLE -> WAIT -> FILL -> IDLE.
- IDLE:
  - If either miss is high, pick the owner by priority.
  - Latch mem_addr = {addr[ADDR_W-1:4],4'b0} and set mem_req=1 at the same edge. Go to WAIT.
  - mem_ready in IDLE is ignored.
- WAIT:
  - mem_req and mem_addr are held stable.
  - On the first edge with mem_ready=1: fill_data<=mem_rdata, fill_addr<=mem_addr, mem_req<=0, assert the owner's fill strobe, go to FILL.
  - Latency from miss to fill strobe is 2 cycles plus memory latency; minimum 2 when mem_ready is already high in the first WAIT cycle.
- FILL: exactly one cycle with i_fill or d_fill high, never both. Strobes clear next edge; go to IDLE. The cache writes at the end of FILL, so its miss is low in the following IDLE cycle.
- Timeout:
  - The counter increments every WAIT cycle without mem_ready.
  - When it reaches TIMEOUT: mem_req<=0, err<=1 (sticky until reset), no fill strobe, return to IDLE.
  - The still-high miss re-arbitrates and retries.
- Priority (default): D over I when both misses are high in IDLE.
- Miss withdrawn during WAIT (e.g. branch redirect): the transaction still completes and the fill strobe is still issued. A line is valid regardless of who wanted it.
- New misses arriving while busy wait; there is no preemption.
- Stalls (combinational):
  - stall_fetch = i_miss | (busy & owner==I).
  - stall_mem = d_miss | (busy & owner==D).
  - busy = (state != IDLE).
- fill_data and fill_addr hold their last value outside FILL.

Optional Feature:
- Macro: ICACHE_REFILL_RR_EN.
- Defined: round-robin arbitration. On simultaneous misses, grant the requester not equal to last_grant. last_grant updates at each grant. It resets to D, so I wins the first tie.
- Undefined: fixed D-over-I priority. last_grant logic is absent.

Decomposition:
- Package refill_arb_pkg:
  - state encoding typedef (IDLE, WAIT, FILL).
  - owner typedef (OWN_I, OWN_D).
  - LINE_OFFSET_BITS=4 constant.
  - Default LINE_W/ADDR_W localparams.
- Sub-module refill_timeout_ctr:
  - Inputs clear and count_en.
  - Output expired.
  - Parameterised by TIMEOUT; async active-low reset.

Test Plan:
- I-miss only, i_addr=0x0000_0104, mem_ready 3 cycles after mem_req -> mem_addr=0x0000_0100 and stall_fetch high throughout. The fill_data/fill_addr/i_fill checks:
  - fill_data = mem_rdata 0xFFFFFFFF_00000000_FFFFFFFF_00007C00.
  - fill_addr=0x100.
  - i_fill pulses exactly 1 cycle.
  - d_fill stays 0.
- i_miss and d_miss rise together (i_addr=0x40, d_addr=0x80), mem_ready in first WAIT cycle -> default: d_fill first (mem_addr=0x80), then i_fill (0x40); with ICACHE_REFILL_RR_EN: i_fill first, then d_fill.
- mem_ready held low, TIMEOUT=8 -> mem_req drops after 8 WAIT cycles, err=1 and stays 1, no fill strobe; mem_ready then answers the retry -> fill completes, err still 1.
- Assert rst=0 mid-WAIT -> mem_req, busy and err go 0 without a clock edge. After release with no misses, state remains IDLE.
- i_miss withdrawn during WAIT -> i_fill still pulses on mem_ready and stall_fetch is held until FILL ends. mem_ready pulsed while IDLE -> no strobe.
